led_pulse_stretcher: RTL and testbench

Output-side counterpart of the button debouncer. It takes single-cycle event pulses in the 100 MHz clock domain and turns each one into a human-visible LED blink of fixed on-time, followed by a fixed off-gap. Pulses that arrive while a blink is in progress are queued in a saturating counter and replayed as further blinks. It sits between control logic (fed by debounced key pulses) and the board LED pins.

---
 rtl/led_pulse_stretcher.sv | 205 ++++++++++++++++++++
 tb/tb_led_pulse_stretcher.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// led_pulse_stretcher
//
// Turns single-cycle event pulses into human-visible LED blinks. Each accepted
// event produces one blink: LED lit for ON_CYCLES clocks, followed by a
// mandatory dark gap of OFF_CYCLES clocks. Events arriving while a blink is in
// progress are queued in a saturating counter and replayed as further blinks,
// back to back, with a period of ON_CYCLES+OFF_CYCLES.
//
// Parameters:
//   CLK_FREQ_HZ  system clock frequency in Hz
//   ON_TIME_MS   LED on-time per blink in milliseconds
//   OFF_TIME_MS  dark gap after each blink in milliseconds
//   PENDING_W    width of the pending-event counter (saturates at all-ones)
//   SIM_SHORT    1 selects ON=4 / OFF=3 cycles for fast simulation
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        synchronous reset, active-low
//   pulse_in       event request; every high cycle counts as one event
//   led_out        registered LED drive, high = lit
//   busy           registered, high whenever a blink or its gap is running
//   pending_count  events accepted but not yet started
//   overflow       sticky flag, set when an event is dropped at saturation
// -----------------------------------------------------------------------------
module led_pulse_stretcher #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int ON_TIME_MS  = 100,
    parameter int OFF_TIME_MS = 100,
    parameter int PENDING_W   = 4,
    parameter int SIM_SHORT   = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pulse_in,
    output logic                 led_out,
    output logic                 busy,
    output logic [PENDING_W-1:0] pending_count,
    output logic                 overflow
);

    // -------------------------------------------------------------------------
    // Timing constants. The ms-to-cycles product is formed in 64 bits because
    // e.g. 100 ms * 100 MHz already exceeds the 32-bit range before the /1000.
    // -------------------------------------------------------------------------
    localparam longint ON_CYCLES_L  = (longint'(ON_TIME_MS)  * longint'(CLK_FREQ_HZ)) / longint'(1000);
    localparam longint OFF_CYCLES_L = (longint'(OFF_TIME_MS) * longint'(CLK_FREQ_HZ)) / longint'(1000);

    localparam int ON_CYCLES  = (SIM_SHORT != 0) ? 4 : int'(ON_CYCLES_L);
    localparam int OFF_CYCLES = (SIM_SHORT != 0) ? 3 : int'(OFF_CYCLES_L);

    localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;

    // A phase of a single cycle would give $clog2()==0; keep at least one bit
    // so the timer is always a legal vector.
    localparam int TIMER_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [TIMER_W-1:0] TIMER_ZERO = '0;
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [TIMER_W-1:0] ON_LAST    = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST   = TIMER_W'(OFF_CYCLES - 1);

    localparam logic [PENDING_W-1:0] PEND_ZERO = '0;
    localparam logic [PENDING_W-1:0] PEND_ONE  = PENDING_W'(1);
    localparam logic [PENDING_W-1:0] PEND_MAX  = '1;

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]           state_reg;
    logic [1:0]           state_next;
    logic [TIMER_W-1:0]   timer_reg;
    logic [TIMER_W-1:0]   timer_next;
    logic [PENDING_W-1:0] pending_reg;
    logic [PENDING_W-1:0] pending_next;
    logic                 overflow_reg;
    logic                 overflow_next;
    logic                 led_reg;
    logic                 led_next;
    logic                 busy_reg;
    logic                 busy_next;

    // -------------------------------------------------------------------------
    // Decode helpers
    // -------------------------------------------------------------------------
    logic pending_nz;
    logic on_done;
    logic gap_done;
    logic start;

    assign pending_nz = (pending_reg != PEND_ZERO);
    assign on_done    = (timer_reg == ON_LAST);
    assign gap_done   = (timer_reg == OFF_LAST);

    // A new blink may begin from IDLE at once, or from GAP only on its last
    // cycle, so the dark gap is never cut short.
    always_comb begin
        start = 1'b0;
        case (state_reg)
            ST_IDLE: start = pending_nz;
            ST_GAP:  start = gap_done && pending_nz;
            default: start = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ON;
                end
            end
            ST_ON: begin
                if (on_done) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (start) begin
                    state_next = ST_ON;
                end else if (gap_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The timer restarts on every state entry (GAP->ON included, since that is
    // a change of state) and is held at zero while idle so it does not toggle.
    always_comb begin
        timer_next = timer_reg + TIMER_ONE;
        if ((state_next != state_reg) || (state_next == ST_IDLE)) begin
            timer_next = TIMER_ZERO;
        end
    end

    // -------------------------------------------------------------------------
    // Pending-event counter. An incoming event and a blink start in the same
    // cycle cancel out, so the counter only saturates when it genuinely grows.
    // -------------------------------------------------------------------------
    always_comb begin
        pending_next  = pending_reg;
        overflow_next = overflow_reg;
        case ({pulse_in, start})
            2'b10: begin
                if (pending_reg == PEND_MAX) begin
                    overflow_next = 1'b1;
                end else begin
                    pending_next = pending_reg + PEND_ONE;
                end
            end
            2'b01: begin
                // start implies pending_nz, so this never wraps below zero
                pending_next = pending_reg - PEND_ONE;
            end
            default: begin
                pending_next = pending_reg;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the registered copies
    // line up exactly with the state register.
    assign led_next  = (state_next == ST_ON);
    assign busy_next = (state_next != ST_IDLE);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            timer_reg    <= TIMER_ZERO;
            pending_reg  <= PEND_ZERO;
            overflow_reg <= 1'b0;
            led_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            pending_reg  <= pending_next;
            overflow_reg <= overflow_next;
            led_reg      <= led_next;
            busy_reg     <= busy_next;
        end
    end

    assign led_out       = led_reg;
    assign busy          = busy_reg;
    assign pending_count = pending_reg;
    assign overflow      = overflow_reg;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_led_pulse_stretcher
//
// Two instances share clock, reset and pulse input: one with the default
// 4-bit pending counter and one with a 2-bit counter so saturation is reached
// quickly. A timeline model (time since blink start, pending count) predicts
// every output after each edge; expectations are queued by the stimulus
// process and consumed by an independent monitor.
// -----------------------------------------------------------------------------
module tb_led_pulse_stretcher;

    localparam int ON  = 4;
    localparam int OFF = 3;

    logic       clk;
    logic       reset_n;
    logic       pulse_in;
    logic       led_a, busy_a, ovf_a;
    logic [3:0] pend_a;
    logic       led_b, busy_b, ovf_b;
    logic [1:0] pend_b;

    led_pulse_stretcher #(
        .CLK_FREQ_HZ(100_000_000), .ON_TIME_MS(100), .OFF_TIME_MS(100),
        .PENDING_W(4), .SIM_SHORT(1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .pulse_in(pulse_in),
        .led_out(led_a), .busy(busy_a), .pending_count(pend_a), .overflow(ovf_a)
    );

    led_pulse_stretcher #(
        .CLK_FREQ_HZ(100_000_000), .ON_TIME_MS(100), .OFF_TIME_MS(100),
        .PENDING_W(2), .SIM_SHORT(1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .pulse_in(pulse_in),
        .led_out(led_b), .busy(busy_b), .pending_count(pend_b), .overflow(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    typedef struct {
        int pend;
        bit ovf;
        bit active;   // a blink (lit part or its gap) is running
        int t;        // cycles since that blink started
    } mdl_t;

    typedef struct {
        bit led;
        bit busy;
        int pend;
        bit ovf;
    } exp_t;

    typedef struct {
        exp_t a;
        exp_t b;
        int   cyc;
    } item_t;

    item_t sbq[$];
    mdl_t  m_a, m_b;
    int    total = 0;
    int    bad   = 0;
    int    cycle = 0;
    int    rises_b = 0;

    function automatic mdl_t model_step(mdl_t s, bit p, bit rn, int maxv);
        mdl_t n;
        bit   start;
        bit   ending;
        n = s;
        if (!rn) begin
            n.pend = 0; n.ovf = 1'b0; n.active = 1'b0; n.t = 0;
            return n;
        end
        ending = s.active && (s.t == ON + OFF - 1);
        start  = (s.pend != 0) && (!s.active || ending);
        if (p && !start) begin
            if (s.pend == maxv) n.ovf = 1'b1;
            else                n.pend = s.pend + 1;
        end else if (!p && start) begin
            n.pend = s.pend - 1;
        end
        if (start) begin
            n.active = 1'b1; n.t = 0;
        end else if (ending) begin
            n.active = 1'b0; n.t = 0;
        end else if (s.active) begin
            n.t = s.t + 1;
        end
        return n;
    endfunction

    function automatic exp_t model_out(mdl_t s);
        exp_t e;
        e.led  = s.active && (s.t < ON);
        e.busy = s.active;
        e.pend = s.pend;
        e.ovf  = s.ovf;
        return e;
    endfunction

    // ---------------------------------------------------------------- checks
    task automatic chk(input string name, input int act, input int exp_v, input int cyc);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp_v);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        item_t it;
        bit    prev_led_b;
        prev_led_b = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                it = sbq.pop_front();
                chk("led_a",  int'(led_a),  int'(it.a.led),  it.cyc);
                chk("busy_a", int'(busy_a), int'(it.a.busy), it.cyc);
                chk("pend_a", int'(pend_a), it.a.pend,       it.cyc);
                chk("ovf_a",  int'(ovf_a),  int'(it.a.ovf),  it.cyc);
                chk("led_b",  int'(led_b),  int'(it.b.led),  it.cyc);
                chk("busy_b", int'(busy_b), int'(it.b.busy), it.cyc);
                chk("pend_b", int'(pend_b), it.b.pend,       it.cyc);
                chk("ovf_b",  int'(ovf_b),  int'(it.b.ovf),  it.cyc);
                $display("cyc=%0d rn=%0b p=%0b a:led=%0b busy=%0b pend=%0d ovf=%0b b:led=%0b busy=%0b pend=%0d ovf=%0b",
                         it.cyc, reset_n, pulse_in, led_a, busy_a, pend_a, ovf_a,
                         led_b, busy_b, pend_b, ovf_b);
            end
            if (led_b && !prev_led_b) rises_b++;
            prev_led_b = led_b;
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic step(input bit p, input bit rn);
        item_t it;
        @(negedge clk);
        pulse_in = p;
        reset_n  = rn;
        m_a = model_step(m_a, p, rn, 15);
        m_b = model_step(m_b, p, rn, 3);
        it.a   = model_out(m_a);
        it.b   = model_out(m_b);
        it.cyc = cycle;
        sbq.push_back(it);
        cycle++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain_timeout", sbq.size(), 0, cycle);
    endtask

    initial begin : stim
        int r0;
        pulse_in = 1'b0;
        reset_n  = 1'b0;
        m_a.pend = 0; m_a.ovf = 1'b0; m_a.active = 1'b0; m_a.t = 0;
        m_b = m_a;

        // reset with pulse_in toggling
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        idle(3);

        // single pulse
        step(1'b1, 1'b1);
        idle(12);

        // three pulses back to back
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        idle(26);

        // pulse coincident with the GAP-end start (pending=1 going into edge 8)
        step(1'b1, 1'b1); step(1'b1, 1'b1);
        idle(6);
        step(1'b1, 1'b1);
        idle(30);

        // saturation of the 2-bit counter: exactly four blinks on dut_b
        step(1'b0, 1'b0);
        idle(1);
        drain();
        r0 = rises_b;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
        idle(40);
        drain();
        chk("sat_blinks_b", rises_b - r0, 4, cycle);
        idle(40);

        // reset at the third ON edge with pending=2, then stay dark
        step(1'b0, 1'b0);
        idle(1);
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        idle(20);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 399) != 0));
        end
        idle(2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
